// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |a|<|b| skip the iteration.
module div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic            word,
   input  logic [XLEN-1:0] operand_1,
   input  logic [XLEN-1:0] operand_2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_dvd;
   logic [XLEN-1:0] r_dvs;
   logic [XLEN-1:0] r_result;
   logic [CW-1:0]   r_cnt;
   logic            r_sign_q;
   logic            r_sign_r;
   logic            r_is_rem;
   logic            r_word;
   logic            r_div0;
   logic            r_out_valid;

   logic            w_accept;
   logic            w_signed;
   logic            w_word;
   logic            w_sa;
   logic            w_sb;
   logic            w_b_zero;
   logic            w_qbit;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic [XLEN-1:0] w_dvd_init;
   logic [XLEN-1:0] w_rem_nx;
   logic [XLEN-1:0] w_quo_nx;
   logic [XLEN-1:0] w_q_fix;
   logic [XLEN-1:0] w_r_fix;
   logic [XLEN-1:0] w_res_calc;
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_diff;
   logic [CW-1:0]   w_cnt_init;

   function automatic logic [XLEN-1:0] f_ext32(input logic [XLEN-1:0] v, input logic sgn);
      logic [XLEN-1:0] x;
      x = v;
      for (int i = 32; i < XLEN; i++) begin
         x[i] = sgn & v[31];
      end
      return x;
   endfunction

   function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v, input logic en);
      return en ? ({XLEN{1'b0}} - v) : v;
   endfunction

   function automatic logic [XLEN-1:0] f_final(input logic [XLEN-1:0] v, input logic wd);
      return wd ? f_ext32(v, 1'b1) : v;
   endfunction

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;

   // funct3[2] is set for every divide op, so nothing else is ever accepted
   assign w_accept   = in_valid & in_ready & ~flush & funct3[2];
   assign w_signed   = ~funct3[0];
   assign w_word     = (XLEN > 32) & word;
   assign w_a        = w_word ? f_ext32(operand_1, w_signed) : operand_1;
   assign w_b        = w_word ? f_ext32(operand_2, w_signed) : operand_2;
   assign w_sa       = w_signed & w_a[XLEN-1];
   assign w_sb       = w_signed & w_b[XLEN-1];
   assign w_mag_a    = f_neg(w_a, w_sa);
   assign w_mag_b    = f_neg(w_b, w_sb);
   assign w_b_zero   = (w_b == {XLEN{1'b0}});
   // word dividends are left-aligned so the iteration always pulls from the MSB
   assign w_dvd_init = w_word ? (w_mag_a << (XLEN - 32)) : w_mag_a;
   assign w_cnt_init = w_word ? CW'(31) : CW'(XLEN - 1);

   assign w_rem_sh   = {r_rem, r_dvd[XLEN-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_dvs};
   assign w_qbit     = ~w_diff[XLEN];
   assign w_rem_nx   = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
   assign w_quo_nx   = {r_dvd[XLEN-2:0], w_qbit};
   assign w_q_fix    = r_div0 ? {XLEN{1'b1}} : f_neg(w_quo_nx, r_sign_q);
   assign w_r_fix    = f_neg(w_rem_nx, r_sign_r);
   assign w_res_calc = f_final(r_is_rem ? w_r_fix : w_q_fix, r_word);

`ifdef DIV_EARLY_OUT_EN
   logic            w_ovf;
   logic            w_early;
   logic [XLEN-1:0] w_min;
   logic [XLEN-1:0] w_early_q;
   logic [XLEN-1:0] w_early_r;
   logic [XLEN-1:0] w_res_early;

   assign w_min       = w_word ? f_ext32(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
   assign w_ovf       = w_signed & (w_a == w_min) & (w_b == {XLEN{1'b1}});
   assign w_early     = w_b_zero | w_ovf | (w_mag_a < w_mag_b);
   assign w_early_q   = w_b_zero ? {XLEN{1'b1}} : (w_ovf ? w_a : {XLEN{1'b0}});
   assign w_early_r   = w_ovf ? {XLEN{1'b0}} : w_a;
   assign w_res_early = f_final(funct3[1] ? w_early_r : w_early_q, w_word);
`endif

   // Control FSM and iteration datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rem       <= {XLEN{1'b0}};
         r_dvd       <= {XLEN{1'b0}};
         r_dvs       <= {XLEN{1'b0}};
         r_result    <= {XLEN{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         r_is_rem    <= 1'b0;
         r_word      <= 1'b0;
         r_div0      <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_state     <= S_IDLE;
         r_cnt       <= {CW{1'b0}};
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rem    <= {XLEN{1'b0}};
                  r_dvd    <= w_dvd_init;
                  r_dvs    <= w_mag_b;
                  r_cnt    <= w_cnt_init;
                  r_sign_q <= w_sa ^ w_sb;
                  r_sign_r <= w_sa;
                  r_is_rem <= funct3[1];
                  r_word   <= w_word;
                  r_div0   <= w_b_zero;
`ifdef DIV_EARLY_OUT_EN
                  if (w_early) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_res_early;
                  end else begin
                     r_state <= S_CALC;
                  end
`else
                  r_state <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nx;
               r_dvd <= w_quo_nx;
               if (r_cnt == {CW{1'b0}}) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_res_calc;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (XLEN=64); expected results queued at issue, popped at out_valid.
module tb_div_unit;
   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  funct3;
   logic        word;
   logic [63:0] operand_1;
   logic [63:0] operand_2;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] sb_q[$];

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   typedef struct {
      logic [2:0]  f3;
      logic        wd;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      bit          sp;
   } vec_t;

   div_unit #(.XLEN(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .word      (word),
      .operand_1 (operand_1),
      .operand_2 (operand_2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_lat(input bit wd, input bit sp);
      if (sp && EARLY_EN) return 1;
      return wd ? 33 : 65;
   endfunction

   task automatic issue(input logic [2:0] f3, input logic wd, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] r, input bit push);
      if (push) sb_q.push_back(r);
      funct3    = f3;
      word      = wd;
      operand_1 = a;
      operand_2 = b;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   // lat counts cycles from the accept edge; -1 when out_valid never came
   task automatic collect(output logic [63:0] got, output logic [63:0] want, output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
      got = result;
      if (sb_q.size() > 0) want = sb_q.pop_front();
      else want = 64'hx;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      checks++;
      if (result !== 64'h0) begin errors++; $display("FAIL reset result: got %h expected 0", result); end
   endtask

   task automatic test_div_signed();
      logic [63:0] got, want;
      int lat;
      vec_t v[6] = '{
         '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
         '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
         '{3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
         '{3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0},
         '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0},
         '{3'b111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 1'b0}
      };
      foreach (v[i]) begin
         issue(v[i].f3, v[i].wd, v[i].a, v[i].b, v[i].r, 1'b1);
         collect(got, want, lat);
         checks++;
         if (got !== want) begin errors++; $display("FAIL full[%0d] result: got %h expected %h", i, got, want); end
         checks++;
         if (lat !== exp_lat(v[i].wd, v[i].sp)) begin
            errors++; $display("FAIL full[%0d] latency: got %0d expected %0d", i, lat, exp_lat(v[i].wd, v[i].sp));
         end
      end
   endtask

   task automatic test_word();
      logic [63:0] got, want;
      int lat;
      vec_t v[5] = '{
         '{3'b101, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0},
         '{3'b101, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0},
         '{3'b100, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
         '{3'b110, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
         '{3'b111, 1'b1, 64'h0000_0000_9000_0000, 64'h0000_0000_A000_0000, 64'hFFFF_FFFF_9000_0000, 1'b1}
      };
      foreach (v[i]) begin
         issue(v[i].f3, v[i].wd, v[i].a, v[i].b, v[i].r, 1'b1);
         collect(got, want, lat);
         checks++;
         if (got !== want) begin errors++; $display("FAIL word[%0d] result: got %h expected %h", i, got, want); end
         checks++;
         if (lat !== exp_lat(v[i].wd, v[i].sp)) begin
            errors++; $display("FAIL word[%0d] latency: got %0d expected %0d", i, lat, exp_lat(v[i].wd, v[i].sp));
         end
      end
   endtask

   task automatic test_special();
      logic [63:0] got, want;
      int lat;
      vec_t v[12] = '{
         '{3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
         '{3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1},
         '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1},
         '{3'b101, 1'b1, 64'd7, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
         '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1},
         '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1},
         '{3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1},
         '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1},
         '{3'b101, 1'b0, 64'd3, 64'd10, 64'd0, 1'b1},
         '{3'b111, 1'b0, 64'd3, 64'd10, 64'd3, 1'b1},
         '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1},
         '{3'b100, 1'b0, 64'd10, 64'd10, 64'd1, 1'b0}
      };
      foreach (v[i]) begin
         issue(v[i].f3, v[i].wd, v[i].a, v[i].b, v[i].r, 1'b1);
         collect(got, want, lat);
         checks++;
         if (got !== want) begin errors++; $display("FAIL special[%0d] result: got %h expected %h", i, got, want); end
         checks++;
         if (lat !== exp_lat(v[i].wd, v[i].sp)) begin
            errors++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, exp_lat(v[i].wd, v[i].sp));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] got, want;
      int lat;
      int n;
      issue(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid: got %b expected 1", out_valid); end
      want = sb_q.pop_front();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (result !== want || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp hold[%0d]: result=%h in_ready=%b out_valid=%b expected %h/0/1", c, result, in_ready, out_valid, want);
         end
         @(posedge clk); #1;
      end
      sb_q.push_back(64'd100);
      funct3 = 3'b101; word = 1'b0; operand_1 = 64'd1000; operand_2 = 64'd10;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp second accept: in_ready=%b expected 0", in_ready); end
      collect(got, want, lat);
      checks++;
      if (got !== want) begin errors++; $display("FAIL bp second result: got %h expected %h", got, want); end
      checks++;
      if (lat !== 65) begin errors++; $display("FAIL bp second latency: got %0d expected 65", lat); end
   endtask

   task automatic test_flush();
      logic [63:0] got, want;
      int lat;
      bit seen;
      issue(3'b100, 1'b0, 64'd1000, 64'd3, 64'd333, 1'b0);
      repeat (20) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL flush idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      funct3 = 3'b101; word = 1'b0; operand_1 = 64'd9; operand_2 = 64'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL flush blocks accept: in_ready=%b expected 1", in_ready); end
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL flush no output: out_valid seen=%b expected 0", seen); end
      issue(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1);
      collect(got, want, lat);
      checks++;
      if (got !== want) begin errors++; $display("FAIL flush recover: got %h expected %h", got, want); end
   endtask

   task automatic test_async_reset();
      logic [63:0] got, want;
      int lat;
      issue(3'b100, 1'b0, 64'd12345, 64'd6, 64'd2057, 1'b0);
      repeat (10) begin @(posedge clk); #1; end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0) begin
         errors++; $display("FAIL async reset: in_ready=%b out_valid=%b result=%h expected 1/0/0", in_ready, out_valid, result);
      end
      @(posedge clk); #3;
      reset = 1'b0;
      @(posedge clk); #1;
      issue(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1);
      collect(got, want, lat);
      checks++;
      if (got !== want) begin errors++; $display("FAIL post reset divu: got %h expected %h", got, want); end
      checks++;
      if (lat !== 65) begin errors++; $display("FAIL post reset latency: got %0d expected 65", lat); end
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      funct3    = 3'b100;
      word      = 1'b0;
      operand_1 = 64'h0;
      operand_2 = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      test_div_signed();
      test_word();
      test_special();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
